// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD encoder (shift-and-add-3), one input bit per clock.
// Produces packed BCD digits plus a count of significant digits.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [BIN_W-1:0]                 bin,
  output logic                             busy,
  output logic                             done,
  output logic [4*DIGITS-1:0]              bcd,
  output logic [$clog2(DIGITS+1)-1:0]      ndig
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned NDIG_W = $clog2(DIGITS + 1);
  localparam int unsigned CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned V_W    = BIN_W + 4;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  // Decimal digits needed to represent the largest BIN_W-bit value.
  function automatic int unsigned f_digits_needed();
    logic [V_W-1:0] v;
    int unsigned    n;
    v = {4'b0000, {BIN_W{1'b1}}};
    n = 0;
    while (v != '0) begin
      v = v / V_W'(10);
      n++;
    end
    return n;
  endfunction

  localparam int unsigned NEED_DIGITS = f_digits_needed();

  if (DIGITS < NEED_DIGITS) begin : g_digits_too_small
    $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
  end

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_accept;
  logic                w_last;

  logic [BIN_W-1:0]    r_shift;
  logic [BCD_W-1:0]    r_scr;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_busy;
  logic                r_done;
  logic [BCD_W-1:0]    r_bcd;
  logic [NDIG_W-1:0]   r_ndig;

  logic [BCD_W-1:0]    w_adj;
  logic [BCD_W-1:0]    w_scr_nxt;
  logic [NDIG_W-1:0]   w_ndig;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; start is only honoured while idle
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Add 3 to every digit >= 5 before the shift; digits never carry into each other
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_scr[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
      end else begin
        w_adj[4*i +: 4] = r_scr[4*i +: 4];
      end
    end
  end

  assign w_scr_nxt = {w_adj[BCD_W-2:0], r_shift[BIN_W-1]};

  // Significant digit count of the post-shift scratch (minimum one digit)
  always_comb begin
    w_ndig = NDIG_W'(1);
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (w_scr_nxt[4*i +: 4] != 4'd0) begin
        w_ndig = NDIG_W'(i + 1);
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_scr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
      r_ndig  <= NDIG_W'(1);
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift <= bin;
        r_scr   <= '0;
        r_cnt   <= '0;
        r_busy  <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        r_shift <= r_shift << 1;
        r_scr   <= w_scr_nxt;
        r_cnt   <= r_cnt + CNT_W'(1);
        if (w_last) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_bcd  <= w_scr_nxt;
          r_ndig <= w_ndig;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
  assign ndig = r_ndig;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: directed conversions, ignored starts,
// back-to-back operation and mid-conversion reset.
module tb_bin_to_bcd_seq;

  localparam int unsigned BIN_W  = 32;
  localparam int unsigned DIGITS = 10;

  typedef struct packed {
    logic [39:0] bcd;
    logic [3:0]  ndig;
  } exp_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic [31:0] bin     = '0;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic [3:0]  ndig;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  exp_t        m_e;
  logic        m_bad;
  logic [39:0] m_prev_bcd;
  logic [3:0]  m_prev_ndig;

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bin     (bin),
    .busy    (busy),
    .done    (done),
    .bcd     (bcd),
    .ndig    (ndig)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference by repeated division, independent of the shift-and-add method
  function automatic exp_t model(input logic [31:0] v);
    exp_t        e;
    logic [31:0] x;
    x      = v;
    e.bcd  = '0;
    e.ndig = 4'd1;
    for (int i = 0; i < 10; i++) begin
      e.bcd[4*i +: 4] = 4'(x % 10);
      if ((x % 10) != 0) e.ndig = 4'(i + 1);
      x = x / 10;
    end
    return e;
  endfunction

  // Monitor: compare every done against the scoreboard; flag output changes outside done
  always @(negedge clk) begin
    if (!reset_n) begin
      m_prev_bcd  <= bcd;
      m_prev_ndig <= ndig;
    end else begin
      if (done) begin
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: actual bcd=%0h required no done", bcd);
        end else begin
          m_e = q.pop_front();
          check("bcd", 64'(bcd), 64'(m_e.bcd));
          check("ndig", 64'(ndig), 64'(m_e.ndig));
        end
        m_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
          if (bcd[4*i +: 4] > 4'd9) m_bad = 1'b1;
        end
        check("digit_valid", 64'(m_bad), 64'd0);
      end else if ((bcd !== m_prev_bcd) || (ndig !== m_prev_ndig)) begin
        n_checks++;
        n_fail++;
        $display("FAIL output_stable: actual bcd=%0h ndig=%0d required bcd=%0h ndig=%0d",
                 bcd, ndig, m_prev_bcd, m_prev_ndig);
      end
      m_prev_bcd  <= bcd;
      m_prev_ndig <= ndig;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One conversion; optional extra start pulses while busy and optional reset abort
  task automatic run_conv(input logic [31:0] v, input logic push, input logic [39:0] e_bcd,
                          input logic [3:0] e_ndig, input int abort_at, input int ign_a,
                          input int ign_b);
    int          k;
    int          busy_cnt;
    logic        got;
    logic [39:0] old_bcd;
    exp_t        e;
    @(negedge clk);
    old_bcd = bcd;
    bin     = v;
    start   = 1'b1;
    if (push) begin
      e.bcd  = e_bcd;
      e.ndig = e_ndig;
      q.push_back(e);
    end
    step();
    start = 1'b0;
    bin   = ~v;
    check("busy_after_start", 64'(busy), 64'd1);
    busy_cnt = 1;
    k        = 0;
    got      = 1'b0;
    while (k < 100 && !got) begin
      if (k == ign_a || k == ign_b) begin
        start = 1'b1;
        bin   = 32'd999;
      end else begin
        start = 1'b0;
      end
      step();
      k++;
      if (k == 10) check("bcd_hold", 64'(bcd), 64'(old_bcd));
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_bcd", 64'(bcd), 64'd0);
        check("abort_ndig", 64'(ndig), 64'd1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        repeat (40) step();
        check("abort_idle", 64'(busy), 64'd0);
        return;
      end
      if (done) got = 1'b1;
      else if (busy) busy_cnt++;
    end
    start = 1'b0;
    check("latency", 64'(k), 64'(BIN_W));
    check("busy_cycles", 64'(busy_cnt), 64'(BIN_W));
    check("busy_at_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int k;
    #2 reset_n = 1'b0;
    repeat (3) step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_bcd", 64'(bcd), 64'd0);
    check("rst_ndig", 64'(ndig), 64'd1);
    @(negedge clk);
    #1 reset_n = 1'b1;
    repeat (2) step();

    run_conv(32'd0,          1'b1, 40'h00_0000_0000, 4'd1,  -1, -1, -1);
    run_conv(32'hFFFF_FFFF,  1'b1, 40'h42_9496_7295, 4'd10, -1, -1, -1);
    run_conv(32'd1234,       1'b1, 40'h00_0000_1234, 4'd4,  -1, -1, -1);
    run_conv(32'd9,          1'b1, 40'h00_0000_0009, 4'd1,  -1, -1, -1);
    run_conv(32'd10,         1'b1, 40'h00_0000_0010, 4'd2,  -1, -1, -1);
    run_conv(32'd100,        1'b1, 40'h00_0000_0100, 4'd3,  -1,  5, 20);
    repeat (40) step();
    check("ignored_start_idle", 64'(busy), 64'd0);

    // start held high: each new word is accepted in the done cycle of the previous one
    start = 1'b1;
    for (int v = 0; v < 1000; v++) begin
      k = 0;
      while (busy && k < 100) begin
        step();
        k++;
      end
      if (v > 0) check("done_on_accept", 64'(done), 64'd1);
      bin = 32'(v);
      q.push_back(model(32'(v)));
      k = 0;
      while (!busy && k < 5) begin
        step();
        k++;
      end
      check("b2b_accept", 64'(busy), 64'd1);
    end
    start = 1'b0;
    k = 0;
    while (busy && k < 100) begin
      step();
      k++;
    end
    check("b2b_finish", 64'(busy), 64'd0);
    repeat (3) step();

    run_conv(32'd55555,      1'b0, 40'h0,            4'd0,  16, -1, -1);
    run_conv(32'd7,          1'b1, 40'h00_0000_0007, 4'd1,  -1, -1, -1);

    k = 0;
    while (q.size() > 0 && k < 100) begin
      step();
      k++;
    end
    repeat (5) step();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
